fizzbuzz_gen: RTL and testbench

FIZZBUZZ_GEN -- requirements
Module: fizzbuzz_gen

---
 rtl/fizzbuzz_gen.sv | 125 ++++++++++++
 tb/tb_fizzbuzz_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fizzbuzz_gen.sv
// FizzBuzz sequence generator with a valid/ready output stream.
// Residue counters replace any divide or modulo logic.
module fizzbuzz_gen #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_fizz,
  output logic             out_buzz,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [1:0]       mod3_q, mod3_d;
  logic [2:0]       mod5_q, mod5_d;
  logic             fizz_q, fizz_d;
  logic             buzz_q, buzz_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             xfer;
  logic [1:0]       mod3_nx;
  logic [2:0]       mod5_nx;

  assign xfer    = valid_q & out_ready;
  assign mod3_nx = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
  assign mod5_nx = (mod5_q == 3'd4) ? 3'd0 : mod5_q + 3'd1;

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    mod3_d  = mod3_q;
    mod5_d  = mod5_q;
    fizz_d  = fizz_q;
    buzz_d  = buzz_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          value_d = WIDTH'(1);
          mod3_d  = 2'd1;
          mod5_d  = 3'd1;
          fizz_d  = 1'b0;
          buzz_d  = 1'b0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (value_q == LAST) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // flags follow the residues being loaded, keeping them registered
            value_d = value_q + WIDTH'(1);
            mod3_d  = mod3_nx;
            mod5_d  = mod5_nx;
            fizz_d  = (mod3_nx == 2'd0);
            buzz_d  = (mod5_nx == 3'd0);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      value_q <= '0;
      mod3_q  <= '0;
      mod5_q  <= '0;
      fizz_q  <= 1'b0;
      buzz_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      mod3_q  <= mod3_d;
      mod5_q  <= mod5_d;
      fizz_q  <= fizz_d;
      buzz_q  <= buzz_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_value = value_q;
  assign out_fizz  = fizz_q;
  assign out_buzz  = buzz_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fizzbuzz_gen.sv
// Scoreboard bench for fizzbuzz_gen; four instances with LIMIT 15, 5, 100, 1
// share the stimulus, and each scenario checks the instance it targets.
module tb_fizzbuzz_gen;

  typedef struct packed {
    logic [7:0] v;
    logic       f;
    logic       b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            ready = 1'b0;
  logic [3:0]      ov, fz, bz, bs, dn;
  logic [3:0][7:0] val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fizzbuzz_gen #(.WIDTH(8), .LIMIT(15)) u15 (
    .clk(clk), .rst(rst), .start(start),
    .out_valid(ov[0]), .out_ready(ready), .out_value(val[0]),
    .out_fizz(fz[0]), .out_buzz(bz[0]), .busy(bs[0]), .done(dn[0])
  );
  fizzbuzz_gen #(.WIDTH(8), .LIMIT(5)) u5 (
    .clk(clk), .rst(rst), .start(start),
    .out_valid(ov[1]), .out_ready(ready), .out_value(val[1]),
    .out_fizz(fz[1]), .out_buzz(bz[1]), .busy(bs[1]), .done(dn[1])
  );
  fizzbuzz_gen u100 (
    .clk(clk), .rst(rst), .start(start),
    .out_valid(ov[2]), .out_ready(ready), .out_value(val[2]),
    .out_fizz(fz[2]), .out_buzz(bz[2]), .busy(bs[2]), .done(dn[2])
  );
  fizzbuzz_gen #(.WIDTH(8), .LIMIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start),
    .out_valid(ov[3]), .out_ready(ready), .out_value(val[3]),
    .out_fizz(fz[3]), .out_buzz(bz[3]), .busy(bs[3]), .done(dn[3])
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Runs instance k after its RUN entry; stall_at holds ready low for 4
  // cycles on that value, rst_at resets while that value is presented.
  task automatic drain(input int k, input int lim, input int pct,
                       input int stall_at, input int rst_at,
                       output int busy_n, output bit aborted);
    exp_t q[$];
    exp_t e;
    int guard;
    int stalls;
    for (int i = 1; i <= lim; i++) begin
      e.v = 8'(i);
      e.f = (i % 3 == 0);
      e.b = (i % 5 == 0);
      q.push_back(e);
    end
    busy_n = 0;
    aborted = 1'b0;
    guard = 0;
    stalls = 0;
    while (q.size() > 0 && guard < 2000) begin
      guard++;
      if (bs[k]) busy_n++;
      checks++;
      if (ov[k] !== 1'b1 || dn[k] !== 1'b0) begin
        errors++;
        $display("FAIL run_valid k=%0d got valid=%b done=%b want 1 0",
                 k, ov[k], dn[k]);
      end
      if (rst_at != 0 && val[k] == 8'(rst_at)) begin
        rst = 1'b1;
        ready = 1'b1;
        cyc();
        rst = 1'b0;
        ready = 1'b0;
        checks++;
        if ({ov[k], bs[k], dn[k]} !== 3'b000) begin
          errors++;
          $display("FAIL abort_outs got v/b/d=%b want 000",
                   {ov[k], bs[k], dn[k]});
        end
        aborted = 1'b1;
        return;
      end
      if (stall_at != 0 && val[k] == 8'(stall_at) && stalls < 4) begin
        ready = 1'b0;
        stalls++;
        checks++;
        if ({val[k], fz[k], bz[k]} !== q[0]) begin
          errors++;
          $display("FAIL stall_hold got %0d/%b/%b want %0d/%b/%b",
                   val[k], fz[k], bz[k], q[0].v, q[0].f, q[0].b);
        end
        cyc();
        continue;
      end
      ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (ready) begin
        e = q.pop_front();
        checks++;
        if ({val[k], fz[k], bz[k]} !== e) begin
          errors++;
          $display("FAIL xfer k=%0d got %0d/%b/%b want %0d/%b/%b",
                   k, val[k], fz[k], bz[k], e.v, e.f, e.b);
        end
      end
      cyc();
    end
    ready = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout k=%0d got %0d left want 0", k, q.size());
      return;
    end
    checks++;
    if ({ov[k], bs[k], dn[k]} !== 3'b001) begin
      errors++;
      $display("FAIL done_state k=%0d got v/b/d=%b want 001",
               k, {ov[k], bs[k], dn[k]});
    end
    cyc();
    checks++;
    if (dn[k] !== 1'b0 || ov[k] !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse k=%0d got d=%b v=%b want 0 0",
               k, dn[k], ov[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    ready = 1'b1;
    cyc();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if (ov !== 4'b0 || bs !== 4'b0 || dn !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl got v=%b b=%b d=%b want 0", ov, bs, dn);
    end
    checks++;
    if (val !== '0 || fz !== 4'b0 || bz !== 4'b0) begin
      errors++;
      $display("FAIL reset_data got val=%h f=%b b=%b want 0", val, fz, bz);
    end
    repeat (3) cyc();
    checks++;
    if (ov !== 4'b0 || bs !== 4'b0) begin
      errors++;
      $display("FAIL no_autostart got v=%b b=%b want 0", ov, bs);
    end
    ready = 1'b0;
  endtask

  task automatic test_full_run();
    int busy_n;
    bit ab;
    do_reset();
    pulse_start();
    drain(0, 15, 100, 0, 0, busy_n, ab);
    checks++;
    if (busy_n != 15) begin
      errors++;
      $display("FAIL busy_len got %0d want 15", busy_n);
    end
  endtask

  task automatic test_backpressure();
    int busy_n;
    bit ab;
    do_reset();
    pulse_start();
    drain(0, 15, 100, 3, 0, busy_n, ab);
    checks++;
    if (busy_n != 19) begin
      errors++;
      $display("FAIL bp_busy_len got %0d want 19", busy_n);
    end
  endtask

  task automatic test_mid_reset();
    int busy_n;
    bit ab;
    do_reset();
    pulse_start();
    drain(0, 15, 100, 0, 7, busy_n, ab);
    checks++;
    if (ab !== 1'b1) begin
      errors++;
      $display("FAIL abort_seen got %b want 1", ab);
    end
    repeat (3) begin
      checks++;
      if (dn[0] !== 1'b0 || ov[0] !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet got d=%b v=%b want 0 0", dn[0], ov[0]);
      end
      cyc();
    end
    pulse_start();
    drain(0, 15, 100, 0, 0, busy_n, ab);
  endtask

  task automatic test_start_held();
    int busy_n;
    bit ab;
    do_reset();
    start = 1'b1;
    cyc();
    drain(1, 5, 100, 0, 0, busy_n, ab);
    cyc();
    checks++;
    if (ov[1] !== 1'b1 || val[1] !== 8'd1 || bs[1] !== 1'b1) begin
      errors++;
      $display("FAIL restart got v=%b val=%0d b=%b want 1 1 1",
               ov[1], val[1], bs[1]);
    end
    start = 1'b0;
  endtask

  task automatic test_random_ready();
    int busy_n;
    bit ab;
    do_reset();
    pulse_start();
    drain(2, 100, 50, 0, 0, busy_n, ab);
  endtask

  task automatic test_limit_one();
    int busy_n;
    bit ab;
    do_reset();
    pulse_start();
    drain(3, 1, 100, 0, 0, busy_n, ab);
    checks++;
    if (busy_n != 1) begin
      errors++;
      $display("FAIL l1_busy got %0d want 1", busy_n);
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_full_run();
    test_backpressure();
    test_mid_reset();
    test_start_held();
    test_random_ready();
    test_limit_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
